serial_subtractor: RTL

Bit-serial WIDTH-bit subtractor that computes A - B - bin LSB-first, one bit per clock. It instantiates the team's Full_Subractor cell as its single arithmetic element and keeps the borrow in a flip-flop between bits. It sits directly upstream of the full-subtractor cell: it sequences operand bits and borrow into the cell and collects the Diff/Borrow it produces. It uses a start/done handshake, so a controller can issue subtractions back to back.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/Full_Subractor.sv | 18 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ==========================================================================
// serial_sub_pkg : shared state encoding and counter sizing, serial subtractor
// Revision 1.0
// ==========================================================================
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One spare bit keeps WIDTH=1 and powers of two on the same compare path.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/Full_Subractor.sv
`default_nettype none
// ==========================================================================
// Full_Subractor : one-bit full subtractor cell, Diff = a-b-c, Borrow out
// Revision 1.0
// ==========================================================================
module Full_Subractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic Diff,
  output logic Borrow
);

  assign Diff   = a ^ b ^ c;
  assign Borrow = (~a & b) | (~(a ^ b) & c);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ==========================================================================
// serial_subtractor : bit-serial A-B-bin, LSB first, start/done handshake
// Revision 1.0
// ==========================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             cell_diff;
  logic             cell_borrow;

  Full_Subractor u_cell (
    .a      (sa_q[0]),
    .b      (sb_q[0]),
    .c      (brw_q),
    .Diff   (cell_diff),
    .Borrow (cell_borrow)
  );

  assign cnt_d = cnt_q + CW'(1);

  // Result bits enter at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_d = cell_diff;
    end else begin : g_diff_wn
      assign diff_d = {cell_diff, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          diff_q <= diff_d;
          sa_q   <= sa_q >> 1;
          sb_q   <= sb_q >> 1;
          brw_q  <= cell_borrow;
          cnt_q  <= cnt_d;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_DONE;
            bout_q  <= cell_borrow;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        // IDLE, DONE and the unused encoding all behave as "ready to accept".
        default: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a_in;
            sb_q    <= b_in;
            brw_q   <= bin;
            cnt_q   <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
